fround_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision round-to-integral unit for the FPU.

---
 rtl/fround_pkg.sv | 24 ++
 rtl/fround_core.sv | 59 +++++
 rtl/fround_pipe.sv | 67 ++++++
 tb/tb_fround_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fround_pkg.sv
// Shared FPU definitions for the round-to-integral unit: rounding-mode encodings,
// FP32 field widths and the exponent/constant values the rounding rules are written in.
package fround_pkg;

  typedef enum logic [1:0] {
    RM_FLOOR = 2'b00,
    RM_CEIL  = 2'b01,
    RM_TRUNC = 2'b10,
    RM_RNE   = 2'b11
  } rmode_t;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam logic [7:0]  BIAS    = 8'd127;
  localparam logic [7:0]  INT_EXP = 8'd150;
  localparam logic [31:0] POS_ONE = 32'h3F80_0000;
  localparam logic [31:0] NEG_ONE = 32'hBF80_0000;

  typedef struct packed {
    logic [EXP_W+MAN_W:0] y;
    logic                 inexact;
  } fround_res_t;

endpackage

// File: rtl/fround_core.sv
// Combinational FP32 round-to-integral: x, mode -> y, inexact.
// Denormals flush to signed zero; inf/NaN and values >= 2^23 pass through unchanged.
module fround_core
  import fround_pkg::*;
(
  input  logic [31:0] x,
  input  rmode_t      mode,
  output logic [31:0] y,
  output logic        inexact
);

  logic        s, inc, lsb;
  logic [7:0]  e;
  logic [4:0]  n;
  logic [22:0] f, mask, frac, half;
  logic [23:0] sig, m24;

  always_comb begin
    s    = x[31];
    e    = x[30:23];
    f    = x[22:0];
    sig  = {1'b1, f};
    // n is only meaningful for 127<=e<=149 (n = 1..23)
    n    = 5'(INT_EXP - e);
    mask = 23'((32'd1 << n) - 32'd1);
    half = 23'(32'd1 << (n - 5'd1));
    frac = f & mask;
    lsb  = sig[n];

    inc = 1'b0;
    unique case (mode)
      RM_FLOOR: inc = s & (frac != '0);
      RM_CEIL:  inc = !s & (frac != '0);
      RM_TRUNC: inc = 1'b0;
      default:  inc = (frac > half) | ((frac == half) & lsb);
    endcase
    m24 = {1'b0, f & ~mask} + (24'(inc) << n);

    y       = x;
    inexact = 1'b0;
    if (e >= INT_EXP) begin
      y       = x;
    end else if (e == '0) begin
      y       = {s, 31'b0};
    end else if (e < BIAS) begin
      inexact = 1'b1;
      unique case (mode)
        RM_FLOOR: y = s ? NEG_ONE : {s, 31'b0};
        RM_CEIL:  y = s ? {s, 31'b0} : POS_ONE;
        RM_TRUNC: y = {s, 31'b0};
        default:  y = (e == BIAS - 8'd1 && f != '0) ? {s, POS_ONE[30:0]} : {s, 31'b0};
      endcase
    end else begin
      inexact = (frac != '0);
      y       = m24[23] ? {s, e + 8'd1, 23'b0} : {s, e, m24[22:0]};
    end
  end

endmodule

// File: rtl/fround_pipe.sv
// Pipelined FP32 round-to-integral with valid/ready handshake and tag pass-through.
// The result is formed at entry and carried through STAGES elastic register slices.
module fround_pipe
  import fround_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = $bits(fround_res_t) + TAG_W;

  logic [STAGES:0]          vld_pipe;
  logic [STAGES+1:1]        take;
  logic [STAGES:0][PW-1:0]  data_pipe;
  fround_res_t              core_res;

  fround_core u_core (
    .x       (in_x),
    .mode    (rmode_t'(in_mode)),
    .y       (core_res.y),
    .inexact (core_res.inexact)
  );

  assign vld_pipe[0]    = in_valid;
  assign data_pipe[0]   = {core_res, in_tag};
  assign take[STAGES+1] = out_ready;

  // A slice can load when empty or when its content moves on this cycle,
  // so bubbles collapse and a full pipe still sustains one op per cycle.
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic          v;
    logic [PW-1:0] d;

    assign take[k] = !v | take[k+1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v <= 1'b0;
        d <= '0;
      end else if (take[k]) begin
        v <= vld_pipe[k-1];
        if (vld_pipe[k-1]) d <= data_pipe[k-1];
      end
    end

    assign vld_pipe[k]  = v;
    assign data_pipe[k] = d;
  end

  assign in_ready                       = take[1];
  assign out_valid                      = vld_pipe[STAGES];
  assign {out_y, out_inexact, out_tag}  = data_pipe[STAGES];

endmodule

// File: tb/tb_fround_pipe.sv
// Self-checking bench for fround_pipe: directed rounding cases, randomized streams
// against an integer-arithmetic reference model, stall stability and mid-flight reset.
module tb_fround_pipe;

  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int ND     = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_x = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_y;
  logic             out_inexact;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fround_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_inexact(out_inexact), .out_tag(out_tag)
  );

  // mode: 0 floor, 1 ceil, 2 trunc, 3 round-nearest-even
  localparam logic [31:0] DX [ND] = '{
    32'hC0200000, 32'h40200000, 32'h40200000, 32'h40600000,
    32'h3F000000, 32'hBF333333, 32'hBF333333, 32'h4B000001,
    32'h7FC00000, 32'h00000001, 32'h3FFFFFFF, 32'hBFFFFFFF,
    32'h3F000000, 32'h3F800000, 32'h3F000001, 32'h3FC00000};
  localparam logic [1:0] DM [ND] = '{
    2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0,
    2'd3, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd3};
  localparam logic [31:0] DY [ND] = '{
    32'hC0400000, 32'h40400000, 32'h40000000, 32'h40800000,
    32'h00000000, 32'h80000000, 32'hBF800000, 32'h4B000001,
    32'h7FC00000, 32'h00000000, 32'h40000000, 32'hC0000000,
    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
  localparam logic DI [ND] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  // Value-level model: |x| = sig * 2^-n, split into integer part and remainder,
  // round the magnitude by mode, then re-encode the integer as a float.
  function automatic void ref_round(input logic [31:0] x, input logic [1:0] md,
                                    output logic [31:0] y, output logic inx);
    logic   s;
    int     e, n, p;
    longint sig, ip, rem, mag, mant;
    bit     gt, eq, up;
    s   = x[31];
    e   = int'(x[30:23]);
    sig = longint'({1'b1, x[22:0]});
    if (e >= 150) begin y = x; inx = 1'b0; return; end
    if (e == 0)   begin y = {s, 31'b0}; inx = 1'b0; return; end
    n = 150 - e;
    if (n <= 24) begin
      ip  = sig >> n;
      rem = sig - (ip << n);
      gt  = (2 * rem) > (longint'(1) << n);
      eq  = (2 * rem) == (longint'(1) << n);
    end else begin
      ip = 0; rem = 1; gt = 0; eq = 0;
    end
    inx = (rem != 0);
    case (md)
      2'd0:    up = s && inx;
      2'd1:    up = !s && inx;
      2'd2:    up = 0;
      default: up = gt || (eq && ip[0]);
    endcase
    mag = ip + (up ? 1 : 0);
    if (mag == 0) begin
      y = {s, 31'b0};
    end else begin
      p = 0;
      for (int b = 0; b < 40; b++) if (mag[b]) p = b;
      mant = (p <= 23) ? (mag << (23 - p)) : (mag >> (p - 23));
      y = {s, 8'(127 + p), mant[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    logic [22:0] keep;
    int unsigned sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6) r[30:23] = 8'($urandom_range(120, 152));
    else if (sel == 6) r[30:23] = 8'd0;
    else if (sel == 7) r[30:23] = 8'd255;
    else if (sel == 8) begin
      // sparse fractions land on exact halves and integers
      r[30:23] = 8'($urandom_range(126, 150));
      keep     = 23'h7FFFFF;
      keep     = keep << $urandom_range(0, 22);
      r[22:0]  = r[22:0] & keep;
    end
    return r;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 32'h0 || out_inexact !== 1'b0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b y=%h i=%b t=%h rdy=%b exp v=0 y=0 i=0 t=0 rdy=1",
               out_valid, out_y, out_inexact, out_tag, in_ready);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < ND; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_x = DX[i]; in_mode = DM[i]; in_tag = TAG_W'(i); out_ready = 1'b1;
      @(posedge clk); #1;
      // scramble inputs after capture: mode/tag must travel with the op
      in_valid = 1'b0; in_x = $urandom; in_mode = 2'($urandom); in_tag = TAG_W'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      checks++;
      if (out_valid !== 1'b1 || lat != STAGES) begin
        errors++;
        $display("FAIL latency case %0d got %0d cycles exp %0d", i, lat, STAGES);
      end
      checks++;
      if (out_y !== DY[i] || out_inexact !== DI[i] || out_tag !== TAG_W'(i)) begin
        errors++;
        $display("FAIL directed case %0d x=%h mode=%0d got y=%h i=%b t=%0d exp y=%h i=%b t=%0d",
                 i, DX[i], DM[i], out_y, out_inexact, out_tag, DY[i], DI[i], i);
      end
    end
  endtask

  task automatic test_back_to_back(input int nops, input int pct);
    logic [31:0]      ey [$];
    logic             ei [$];
    logic [TAG_W-1:0] et [$];
    logic [31:0]      ry, hy;
    logic             ri, hi, stall, seen;
    logic [TAG_W-1:0] rt, ht;
    int sent, got, cyc, budget;
    sent = 0; got = 0; cyc = 0; budget = nops * 30 + 100;
    stall = 1'b0; hy = '0; hi = 1'b0; ht = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = rand_x(); in_mode = 2'($urandom); in_tag = TAG_W'($urandom);
    out_ready = ($urandom_range(0, 99) < pct);
    while (got < nops && cyc < budget) begin
      @(negedge clk); cyc++;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== hy || out_inexact !== hi || out_tag !== ht) begin
          errors++;
          $display("FAIL stall_hold got v=%b y=%h i=%b t=%h exp v=1 y=%h i=%b t=%h",
                   out_valid, out_y, out_inexact, out_tag, hy, hi, ht);
        end
      end
      if (pct >= 100) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL throughput in_ready got %b exp 1", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (ey.size() == 0) begin
          errors++;
          $display("FAIL extra_output got y=%h t=%h exp none", out_y, out_tag);
        end else begin
          ry = ey.pop_front(); ri = ei.pop_front(); rt = et.pop_front();
          if (out_y !== ry || out_inexact !== ri || out_tag !== rt) begin
            errors++;
            $display("FAIL stream op %0d got y=%h i=%b t=%h exp y=%h i=%b t=%h",
                     got, out_y, out_inexact, out_tag, ry, ri, rt);
          end
          got++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        ref_round(in_x, in_mode, ry, ri);
        ey.push_back(ry); ei.push_back(ri); et.push_back(in_tag);
        sent++;
      end
      stall = (out_valid === 1'b1) && !out_ready;
      hy = out_y; hi = out_inexact; ht = out_tag;
      @(posedge clk); #1;
      in_valid  = (sent < nops) && (pct >= 100 || $urandom_range(0, 99) < 85);
      in_x      = rand_x();
      in_mode   = 2'($urandom);
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 99) < pct);
    end
    if (got < nops) begin
      checks++; errors++;
      $display("FAIL stream_timeout got %0d results exp %0d", got, nops);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < STAGES + 3; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stream_drain got extra result exp none after %0d ops", nops);
    end
  endtask

  task automatic test_reset_midflight();
    int sent, cyc;
    logic bad;
    sent = 0; cyc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_x = 32'h40600000; in_mode = 2'd3; in_tag = 5'd7;
    while (sent < 2 && cyc < 10) begin
      @(negedge clk);
      if (in_ready === 1'b1) sent++;
      @(posedge clk); #1;
      cyc++;
      in_x = rand_x(); in_tag = TAG_W'($urandom);
      if (sent >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (sent == 0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midflight_load got sent=%0d v=%b exp sent>0 v=1", sent, out_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 32'h0) begin
      errors++;
      $display("FAIL midflight_reset got v=%b rdy=%b y=%h exp v=0 rdy=1 y=0", out_valid, in_ready, out_y);
    end
    @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < STAGES + 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_reset_stale got stale valid or in_ready low exp v=0 rdy=1");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(16, 50);
    test_back_to_back(2000, 100);
    test_back_to_back(600, 60);
    test_reset_midflight();
    test_back_to_back(50, 80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
